// File: rtl/hit_manager_if.sv
// Pixel-position, sprite-overlap and player-health signals exchanged with the hit manager.
interface hit_manager_if #(
  parameter int unsigned NUM_BULLETS = 4
);
  logic [9:0]             xx;
  logic [9:0]             yy;
  logic                   aactive;
  logic [NUM_BULLETS-1:0] BulletSpriteOn;
  logic                   HeartSpriteOn;
  logic                   game_start;
  logic [6:0]             HP;
  logic                   HitPulse;
  logic                   Invuln;
  logic                   HitFlash;
  logic                   GameOver;

  modport master (
    output xx, yy, aactive, BulletSpriteOn, HeartSpriteOn, game_start,
    input  HP, HitPulse, Invuln, HitFlash, GameOver
  );

  modport slave (
    input  xx, yy, aactive, BulletSpriteOn, HeartSpriteOn, game_start,
    output HP, HitPulse, Invuln, HitFlash, GameOver
  );
endinterface

// File: rtl/hit_manager.sv
// Player hit detection: collects heart/bullet overlaps over a frame, applies damage at
// frame end, and runs the post-hit invulnerability window and game-over state.
module hit_manager #(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter int unsigned HP_MAX        = 20,
  parameter int unsigned DAMAGE        = 1,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input logic          Pclk,
  input logic          rst_n,
  hit_manager_if.slave hif
);

  localparam int unsigned DW  = 16;
  localparam int unsigned HPW = 7;
  localparam int unsigned CW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_INVULN,
    ST_DEAD
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_BULLETS-1:0] mask, mask_nxt, mask_eval;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [HPW-1:0]         hp, hp_nxt;
  logic                   pulse_nxt;
  logic                   pulse_q, invuln_q, flash_q, over_q;
  logic [DW-1:0]          hits, dmg, hp_wide;
  logic                   fe;

  // Frame-end detect, overlap set including the current pixel, and wide damage amount
  always_comb begin
    fe        = (hif.xx == 10'd639) && (hif.yy == 10'd479);
    mask_eval = mask | ((hif.aactive && hif.HeartSpriteOn) ? hif.BulletSpriteOn : '0);
    hits      = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      hits = hits + DW'(mask_eval[i]);
    end
    dmg     = hits * DW'(DAMAGE);
    hp_wide = DW'(hp);
  end

  // Next-state and datapath; a restart request overrides any frame-end damage
  always_comb begin
    state_nxt = state;
    hp_nxt    = hp;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    mask_nxt  = fe ? '0 : mask_eval;

    if (hif.game_start) begin
      state_nxt = ST_PLAY;
      hp_nxt    = HPW'(HP_MAX);
      cnt_nxt   = '0;
      mask_nxt  = '0;
    end else if (fe) begin
      case (state)
        ST_PLAY: begin
          if (|mask_eval) begin
            pulse_nxt = 1'b1;
            if (dmg >= hp_wide) begin
              hp_nxt    = '0;
              state_nxt = ST_DEAD;
              cnt_nxt   = '0;
            end else begin
              hp_nxt    = HPW'(hp_wide - dmg);
              state_nxt = ST_INVULN;
              cnt_nxt   = CW'(INVULN_FRAMES);
            end
          end
        end
        ST_INVULN: begin
          if (cnt == CW'(1)) begin
            state_nxt = ST_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hp       <= HPW'(HP_MAX);
      cnt      <= '0;
      mask     <= '0;
      pulse_q  <= 1'b0;
      invuln_q <= 1'b0;
      flash_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hp       <= hp_nxt;
      cnt      <= cnt_nxt;
      mask     <= mask_nxt;
      pulse_q  <= pulse_nxt;
      invuln_q <= (state_nxt == ST_INVULN);
      flash_q  <= (state_nxt == ST_INVULN) && !cnt_nxt[0];
      over_q   <= (state_nxt == ST_DEAD);
    end
  end

  assign hif.HP       = hp;
  assign hif.HitPulse = pulse_q;
  assign hif.Invuln   = invuln_q;
  assign hif.HitFlash = flash_q;
  assign hif.GameOver = over_q;

endmodule

// File: tb/tb_hit_manager.sv
// Scoreboard bench for hit_manager: a default instance and a fast-dying instance share
// stimulus; a frame-level model predicts outputs after each frame end.
module tb_hit_manager;

  logic       Pclk;
  logic       rst_n;
  logic [9:0] xx, yy;
  logic       aactive, heart, game_start;
  logic [3:0] bullets;

  hit_manager_if #(.NUM_BULLETS(4)) ifa ();
  hit_manager_if #(.NUM_BULLETS(4)) ifb ();

  assign ifa.xx = xx;  assign ifa.yy = yy;  assign ifa.aactive = aactive;
  assign ifa.BulletSpriteOn = bullets;  assign ifa.HeartSpriteOn = heart;
  assign ifa.game_start = game_start;
  assign ifb.xx = xx;  assign ifb.yy = yy;  assign ifb.aactive = aactive;
  assign ifb.BulletSpriteOn = bullets;  assign ifb.HeartSpriteOn = heart;
  assign ifb.game_start = game_start;

  hit_manager #(.NUM_BULLETS(4), .HP_MAX(20), .DAMAGE(1), .INVULN_FRAMES(30)) u_dut_a (
    .Pclk(Pclk), .rst_n(rst_n), .hif(ifa)
  );
  hit_manager #(.NUM_BULLETS(4), .HP_MAX(12), .DAMAGE(5), .INVULN_FRAMES(2)) u_dut_b (
    .Pclk(Pclk), .rst_n(rst_n), .hif(ifb)
  );

  initial Pclk = 1'b0;
  always #20 Pclk = ~Pclk;

  // Model states: 0 idle, 1 play, 2 invulnerable, 3 dead
  int p_hp[2]  = '{20, 12};
  int p_dmg[2] = '{1, 5};
  int p_inv[2] = '{30, 2};
  int m_hp[2], m_st[2], m_cnt[2], m_pulse[2];

  typedef struct {
    int dut;
    int hp;
    int pulse;
    int inv;
    int flash;
    int go;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Pclk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hp[k] = p_hp[k]; m_st[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_start();
    for (int k = 0; k < 2; k++) begin
      m_hp[k] = p_hp[k]; m_st[k] = 1; m_cnt[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_fe(input logic [3:0] ov, input bit gs);
    int d;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0;
      if (gs) begin
        m_hp[k] = p_hp[k]; m_st[k] = 1; m_cnt[k] = 0;
      end else if (m_st[k] == 1 && ov != 4'd0) begin
        d = $countones(ov) * p_dmg[k];
        m_pulse[k] = 1;
        if (d >= m_hp[k]) begin
          m_hp[k] = 0; m_st[k] = 3; m_cnt[k] = 0;
        end else begin
          m_hp[k] = m_hp[k] - d; m_st[k] = 2; m_cnt[k] = p_inv[k];
        end
      end else if (m_st[k] == 2) begin
        if (m_cnt[k] == 1) begin
          m_st[k] = 1; m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.dut   = k;
      e.hp    = m_hp[k];
      e.pulse = m_pulse[k];
      e.inv   = (m_st[k] == 2) ? 1 : 0;
      e.flash = (m_st[k] == 2 && (m_cnt[k] % 2) == 0) ? 1 : 0;
      e.go    = (m_st[k] == 3) ? 1 : 0;
      sbq.push_back(e);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    logic [6:0] hp_o;
    logic pu, iv, fl, go;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        hp_o = ifa.HP; pu = ifa.HitPulse; iv = ifa.Invuln; fl = ifa.HitFlash; go = ifa.GameOver;
      end else begin
        hp_o = ifb.HP; pu = ifb.HitPulse; iv = ifb.Invuln; fl = ifb.HitFlash; go = ifb.GameOver;
      end
      check($sformatf("hp_d%0d", e.dut),     int'(hp_o), e.hp);
      check($sformatf("pulse_d%0d", e.dut),  int'(pu),   e.pulse);
      check($sformatf("invuln_d%0d", e.dut), int'(iv),   e.inv);
      check($sformatf("flash_d%0d", e.dut),  int'(fl),   e.flash);
      check($sformatf("over_d%0d", e.dut),   int'(go),   e.go);
    end
  endtask

  task automatic idle_inputs();
    xx = 10'd0; yy = 10'd0; aactive = 1'b0; heart = 1'b0; bullets = 4'd0; game_start = 1'b0;
  endtask

  task automatic do_start();
    xx = 10'd5; yy = 10'd5; aactive = 1'b1; heart = 1'b0; bullets = 4'd0; game_start = 1'b1;
    model_start();
    push_expect();
    cyc();
    compare_pop();
    idle_inputs();
  endtask

  // One short frame: 3 active pixels, 2 blanking pixels, then the frame-end pixel
  task automatic run_frame(input logic [3:0] ov, input bit inact, input bit fe_only, input bit gs);
    for (int p = 0; p < 3; p++) begin
      xx = 10'(100 + p); yy = 10'd200; aactive = 1'b1;
      heart = (ov != 4'd0) && !inact && !fe_only; bullets = ov;
      cyc();
    end
    for (int p = 0; p < 2; p++) begin
      xx = 10'(650 + p); yy = 10'd200; aactive = 1'b0;
      heart = inact && (ov != 4'd0); bullets = ov;
      cyc();
    end
    xx = 10'd639; yy = 10'd479; aactive = 1'b1;
    heart = fe_only && (ov != 4'd0); bullets = fe_only ? ov : 4'd0; game_start = gs;
    model_fe(inact ? 4'd0 : ov, gs);
    push_expect();
    cyc();
    compare_pop();
    idle_inputs();
    for (int k = 0; k < 2; k++) m_pulse[k] = 0;
    push_expect();
    cyc();
    compare_pop();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) cyc();
    push_expect();
    compare_pop();
    rst_n = 1'b1;
    cyc();

    // First hit, then 30 frames of overlaps while invulnerable, then a second hit
    do_start();
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 30; f++) run_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);

    // Three bullets in one frame
    do_start();
    run_frame(4'b1101, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 1'b0, 1'b0);

    // Blanking-only overlap is ignored; frame-end-pixel overlap counts
    do_start();
    run_frame(4'b0001, 1'b1, 1'b0, 1'b0);
    run_frame(4'b0010, 1'b0, 1'b1, 1'b0);

    // Restart coincident with a damaging frame end
    do_start();
    run_frame(4'b0001, 1'b0, 1'b0, 1'b1);

    // Hit, then asynchronous reset in the middle of a cycle while invulnerable
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    xx = 10'd300; yy = 10'd100;
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    push_expect();
    compare_pop();
    cyc();
    rst_n = 1'b1;
    cyc();
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);

    // Short-lived instance: 12 -> 7 -> 2, then two bullets at 5 each kill it
    do_start();
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0100, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    run_frame(4'b1111, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0001, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hit_manager.md
HIT_MANAGER -- requirements
Module: hit_manager

Interface
REQ-001 Parameter NUM_BULLETS, default 4, count of bullet sprite-on inputs.
REQ-002 Parameter HP_MAX, default 20, starting hit points (7-bit, 1..127).
REQ-003 Parameter DAMAGE, default 1, HP lost per distinct bullet hitting in one frame.
REQ-004 Parameter INVULN_FRAMES, default 30, frames of invulnerability after a hit (1..255).
REQ-005 Pclk  input  1  25 MHz pixel clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 xx  input  10  current pixel x position.
REQ-008 yy  input  10  current pixel y position.
REQ-009 aactive  input  1  high during active pixel drawing.
REQ-010 BulletSpriteOn  input  NUM_BULLETS  per-bullet sprite-on flags, bit i = bullet i.
REQ-011 HeartSpriteOn  input  1  player heart sprite-on flag.
REQ-012 game_start  input  1  single-cycle request to begin/restart a round.
REQ-013 HP  output  7  current hit points.
REQ-014 HitPulse  output  1  one-cycle strobe when damage is applied.
REQ-015 Invuln  output  1  high while invulnerable.
REQ-016 HitFlash  output  1  heart blink enable, high on even frames of invulnerability.
REQ-017 GameOver  output  1  high once HP reaches 0.

Function
REQ-018 Frame-end tick FE SHALL be true in the cycle where xx==639 and yy==479.
REQ-019 A per-bullet 1-bit sticky mask SHALL set bit i in any cycle with aactive && HeartSpriteOn && BulletSpriteOn[i]; inputs outside aactive are ignored.
REQ-020 On FE the mask SHALL be evaluated including any overlap in the FE cycle itself, then cleared to 0 in the same edge.
REQ-021 States: IDLE, PLAY, INVULN, DEAD; encoding at implementer's discretion.
REQ-022 IDLE: HP=HP_MAX, all strobes low; game_start -> PLAY, mask cleared.
REQ-023 PLAY: on FE with mask nonzero, HP <= HP - popcount(mask)*DAMAGE, saturating at 0, HitPulse high for exactly the next cycle.
REQ-024 PLAY hit with resulting HP==0 -> DEAD; otherwise -> INVULN with frame counter loaded to INVULN_FRAMES.
REQ-025 INVULN: overlaps SHALL be ignored (mask still cleared each FE, no damage); counter decrements on each FE; at FE where counter==1 -> PLAY.
REQ-026 Invuln SHALL be high exactly while in INVULN; HitFlash = Invuln && counter bit 0 == 0.
REQ-027 DEAD: GameOver high, HP held at 0; game_start -> PLAY with HP=HP_MAX, counter 0, mask cleared.
REQ-028 game_start in PLAY or INVULN SHALL restart: HP=HP_MAX, -> PLAY, counter 0, no HitPulse.
REQ-029 game_start coincident with FE SHALL take priority; that frame's damage is discarded.
REQ-030 Damage arithmetic SHALL use at least 12 bits internally so popcount*DAMAGE cannot wrap before saturation.
REQ-031 All outputs SHALL be registered; HitPulse latency is 1 cycle after the FE cycle.

Reset
REQ-032 While rst_n low: state IDLE, HP=HP_MAX, mask=0, counter=0, HitPulse=0, Invuln=0, HitFlash=0, GameOver=0, independent of Pclk.
REQ-033 Reset asserted mid-frame or mid-INVULN SHALL discard pending mask and counter; release requires game_start to resume.

Verification
REQ-034 Reset, game_start, heart and bullet 0 overlap for 3 active pixels in frame 1 -> after FE, HP=19, HitPulse one cycle, Invuln=1.
REQ-035 After hit, overlaps every frame for 30 frames -> HP stays 19; Invuln drops at 30th FE; next overlapped frame -> HP=18.
REQ-036 Bullets 0,2,3 overlap in one frame, DAMAGE=1 -> HP drops by 3 exactly once, single HitPulse.
REQ-037 HP=2, two bullets plus DAMAGE=5 overlap -> HP=0, GameOver=1, state DEAD, Invuln=0; further overlaps no effect.
REQ-038 Overlap only with aactive low, and overlap only in FE cycle (639,479) -> first no damage, second counts.
REQ-039 game_start coincident with damaging FE, and rst_n pulse mid-INVULN -> HP=20, no HitPulse, Invuln=0 in both cases.
